// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - command queue and launch sequencer in front of the I2C master
module i2c_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              master_en,
    output logic              r_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              done,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              master_en_q, master_en_d;
    logic              r_w_en_q, r_w_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

    logic [ENT_W-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    // Full blocks a push even when a pop happens in the same cycle
    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == ST_IDLE) && (count_q != '0);
    assign head      = fifo_mem_q[rd_ptr_q];

    assign master_en = master_en_q;
    assign r_w_en    = r_w_en_q;
    assign mem_addr  = mem_addr_q;
    assign wr_data   = wr_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

    // Queue storage; only entries between the read and write pointers are live
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_wdata};
        end
    end

    // Pointer and occupancy update for simultaneous push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sequencer next state: launch, watchdog-bounded wait, hold response until accepted
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        master_en_d = 1'b0;
        r_w_en_d    = r_w_en_q;
        mem_addr_d  = mem_addr_q;
        wr_data_d   = wr_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    {r_w_en_d, mem_addr_d, wr_data_d} = head;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                master_en_d = 1'b1;
                tmo_cnt_d   = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // done takes priority over a watchdog expiry in the same cycle
                if (done) begin
                    rsp_rdata_d = r_w_en_q ? data_out : '0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tmo_cnt_q   <= '0;
            master_en_q <= 1'b0;
            r_w_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            master_en_q <= master_en_d;
            r_w_en_q    <= r_w_en_d;
            mem_addr_q  <= mem_addr_d;
            wr_data_q   <= wr_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - randomized bench for i2c_cmd_sequencer against a transaction-level model
module tb_i2c_cmd_sequencer;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int TIMEOUT    = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready, cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              master_en, r_w_en, done, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] wr_data, data_out;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .master_en(master_en), .r_w_en(r_w_en), .mem_addr(mem_addr), .wr_data(wr_data),
        .done(done), .data_out(data_out), .busy(busy)
    );

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: commands accepted but not yet launched, plus the one in flight
    cmd_t              exp_cmd[$];
    int                delay_q[$];
    logic [DATA_W-1:0] data_q[$];
    logic [ADDR_W-1:0] launch_log[$];
    cmd_t              cur;
    bit                inflight = 0;
    int                cur_d = 0;
    logic [DATA_W-1:0] cur_data = '0;
    int                lcyc = 0;
    int                exp_rsp_cyc = 0;
    logic              exp_err = 1'b0;
    logic [DATA_W-1:0] exp_rdata = '0;
    bit                prev_men = 0;
    bit                hs_pending = 0;
    bit                stray = 0;
    int                vcnt = 0;
    int                rsp_hold = 0;
    int                n_launch = 0;
    int                n_abort = 0;
    int                n_rsp = 0;
    int                last_launch_cyc = 0;
    int                last_push_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Master transaction time in cycles from master_en to done; 0 means the bus hangs
    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 0;
        if (r == 1) return TIMEOUT;
        if (r == 2) return TIMEOUT + 1;
        if (r == 3) return TIMEOUT - 1;
        return $urandom_range(1, 12);
    endfunction

    task automatic monitor();
        cmd_t c;
        bit   ok;
        if (hs_pending) begin
            check_eq("rsp_drop", rsp_valid, 1'b0);
            inflight   = 0;
            hs_pending = 0;
            vcnt       = 0;
            n_rsp++;
        end
        if (master_en) begin
            check_eq("men_single", prev_men, 1'b0);
            check_eq("launch_idle", inflight, 1'b0);
            if (exp_cmd.size() == 0) begin
                check_eq("launch_spurious", master_en, 1'b0);
                c.rw = r_w_en; c.addr = mem_addr; c.wdata = wr_data;
            end else begin
                c = exp_cmd.pop_front();
                check_eq("launch_rw", r_w_en, c.rw);
                check_eq("launch_addr", mem_addr, c.addr);
                check_eq("launch_wdata", wr_data, c.wdata);
            end
            cur = c;
            launch_log.push_back(mem_addr);
            cur_d    = (delay_q.size() != 0) ? delay_q.pop_front() : pick_delay();
            cur_data = (data_q.size() != 0) ? data_q.pop_front() : DATA_W'($urandom);
            ok          = (cur_d >= 1) && (cur_d <= TIMEOUT);
            exp_err     = !ok;
            exp_rdata   = (ok && cur.rw) ? cur_data : '0;
            lcyc        = cyc;
            exp_rsp_cyc = cyc + (ok ? cur_d : TIMEOUT) + 1;
            last_launch_cyc = cyc;
            inflight = 1;
            n_launch++;
        end else if (inflight) begin
            check_eq("hold_rw", r_w_en, cur.rw);
            check_eq("hold_addr", mem_addr, cur.addr);
            check_eq("hold_wdata", wr_data, cur.wdata);
        end
        prev_men = master_en;

        // master model drives done so that it is sampled cur_d edges after the launch edge
        done     = 1'b0;
        data_out = DATA_W'($urandom);
        if (stray) begin
            done  = 1'b1;
            stray = 0;
        end else if (inflight && cur_d != 0 && cyc == lcyc + cur_d - 1) begin
            done     = 1'b1;
            data_out = cur_data;
        end

        if (rsp_valid) begin
            vcnt++;
            check_eq("rsp_expected", inflight, 1'b1);
            if (vcnt == 1) check_eq("rsp_latency", cyc, exp_rsp_cyc);
            check_eq("rsp_rdata", rsp_rdata, exp_rdata);
            check_eq("rsp_err", rsp_err, exp_err);
        end else if (inflight && cyc >= exp_rsp_cyc) begin
            check_eq("rsp_missing", rsp_valid, 1'b1);
        end

        if (inflight) check_eq("busy_high", busy, 1'b1);
        else if (exp_cmd.size() == 0) check_eq("busy_low", busy, 1'b0);

        if (exp_cmd.size() != FIFO_DEPTH) check_eq("cmd_ready", cmd_ready, exp_cmd.size() < FIFO_DEPTH);

        rsp_ready = rsp_valid && (vcnt > rsp_hold);
    endtask

    task automatic step();
        cmd_t c;
        if (cmd_valid && cmd_ready && !reset) begin
            c.rw = cmd_rw; c.addr = cmd_addr; c.wdata = cmd_wdata;
            exp_cmd.push_back(c);
        end
        if (rsp_valid && rsp_ready && !reset) hs_pending = 1;
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic send(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = w;
        while (!cmd_ready && n < 1000) begin
            step();
            n++;
        end
        check_eq("send_accept", cmd_ready, 1'b1);
        step();
        last_push_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || inflight) && n < 3000) begin
            step();
            n++;
        end
        check_eq("drain_done", (exp_cmd.size() == 0) && !inflight, 1'b1);
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nl;
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; done = 1'b0; data_out = '0;
        repeat (3) step();
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_master_en", master_en, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_addr", mem_addr, '0);
        check_eq("rst_rsp_rdata", rsp_rdata, '0);
        reset = 1'b0;
        repeat (2) step();

        // single write with a 23-cycle master
        delay_q.push_back(23);
        send(1'b0, 7'h55, 8'h55);
        drain();
        check_eq("write_launch_latency", last_launch_cyc - last_push_cyc, 2);
        check_eq("write_rsp_count", n_rsp, 1);

        // a slow read keeps the sequencer busy while four writes fill the queue
        delay_q.push_back(30);
        repeat (4) delay_q.push_back(3);
        send(1'b1, 7'h10, 8'h00);
        send(1'b0, 7'h55, 8'h11);
        send(1'b0, 7'h01, 8'h22);
        send(1'b0, 7'h02, 8'h33);
        send(1'b0, 7'h03, 8'h44);
        check_eq("queue_full_ready", cmd_ready, 1'b0);
        launch_log.delete();
        drain();
        check_eq("queue_launches", launch_log.size(), 4);
        if (launch_log.size() == 4) check_eq("queue_last_addr", launch_log[3], 7'h03);

        // read with host stalling the response for 5 cycles
        rsp_hold = 5;
        delay_q.push_back(6);
        data_q.push_back(8'hAA);
        send(1'b1, 7'h01, 8'h00);
        drain();
        rsp_hold = 0;

        // hung read times out, the following write proceeds normally
        delay_q.push_back(0);
        delay_q.push_back(4);
        send(1'b1, 7'h03, 8'h00);
        send(1'b0, 7'h04, 8'h99);
        drain();

        // done exactly at watchdog expiry wins; one cycle later it is too late
        delay_q.push_back(TIMEOUT);
        data_q.push_back(8'h5A);
        send(1'b1, 7'h05, 8'h00);
        delay_q.push_back(TIMEOUT + 1);
        send(1'b1, 7'h06, 8'h00);
        drain();

        // stray done in IDLE produces nothing
        nl = n_rsp;
        stray = 1;
        repeat (8) step();
        check_eq("stray_no_rsp", n_rsp, nl);
        check_eq("stray_busy", busy, 1'b0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            rsp_hold = $urandom_range(0, 3);
            n = $urandom_range(0, 3);
            repeat (n) step();
            send(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
        end
        drain();
        rsp_hold = 0;

        // reset in the first WAIT cycle with two commands queued
        delay_q.push_back(0);
        send(1'b1, 7'h21, 8'h00);
        send(1'b0, 7'h22, 8'h01);
        send(1'b0, 7'h23, 8'h02);
        n = 0;
        while (!master_en && n < 50) begin
            step();
            n++;
        end
        reset = 1'b1;
        #1;
        check_eq("abort_master_en", master_en, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_rsp_valid", rsp_valid, 1'b0);
        check_eq("abort_cmd_ready", cmd_ready, 1'b1);
        if (inflight) n_abort++;
        exp_cmd.delete();
        delay_q.delete();
        data_q.delete();
        inflight = 0; hs_pending = 0; vcnt = 0; prev_men = 0;
        repeat (3) step();
        reset = 1'b0;
        nl = n_launch;
        repeat (20) step();
        check_eq("post_reset_no_launch", n_launch, nl);
        delay_q.push_back(2);
        send(1'b0, 7'h30, 8'h77);
        drain();
        check_eq("rsp_count", n_rsp, n_launch - n_abort);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
